// File: rtl/axil_irq_ctrl.sv
// AXI-lite interrupt controller: latches rising edges of asynchronous sources into
// pending bits, masks them with an enable register and drives a registered irq.
module axil_irq_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int N_SRC      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic [2:0]                s_axil_awprot,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic [2:0]                s_axil_arprot,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    input  logic [N_SRC-1:0]          src_in,
    output logic                      irq
);

    localparam logic [2:0] IDX_PENDING = 3'd0;
    localparam logic [2:0] IDX_ENABLE  = 3'd1;
    localparam logic [2:0] IDX_STATUS  = 3'd2;
    localparam logic [2:0] IDX_CLAIM   = 3'd3;
    localparam logic [2:0] IDX_COUNT0  = 3'd4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word offsets 0x00..0x10 are mapped; any higher address bit set is a decode miss.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic ok;
        ok = (a[4:2] <= IDX_COUNT0);
        for (int b = 5; b < ADDR_WIDTH; b++) begin
            if (a[b]) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[N_SRC-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 32'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{s[b]}};
        end
        return m;
    endfunction

    logic [N_SRC-1:0] sync1_q, sync2_q, prev_q, edge_s;
    logic [N_SRC-1:0] pending_q, pending_d, enable_q, enable_d, clr_s;
    logic [31:0]      count_q, count_d, wmask_s, rd_val_s;
    logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d, irq_q;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_acc_s, rd_acc_s, wr_ok_s, rd_ok_s, arready_s;
    logic             unused_s;

    assign unused_s = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign edge_s    = sync2_q & ~prev_q;
    assign wr_acc_s  = rst & s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
    assign arready_s = rst & ~rvalid_q;
    assign rd_acc_s  = s_axil_arvalid & arready_s;
    assign wr_ok_s   = addr_ok(s_axil_awaddr);
    assign rd_ok_s   = addr_ok(s_axil_araddr);
    assign wmask_s   = strb_mask(s_axil_wstrb);

    // Register-file next state; a source edge always wins over a same-cycle W1C.
    always_comb begin
        clr_s    = '0;
        enable_d = enable_q;
        count_d  = edge_s[0] ? count_q + 32'd1 : count_q;
        if (wr_acc_s && wr_ok_s) begin
            case (s_axil_awaddr[4:2])
                IDX_PENDING: clr_s    = s_axil_wdata[N_SRC-1:0] & wmask_s[N_SRC-1:0];
                IDX_ENABLE:  enable_d = (enable_q & ~wmask_s[N_SRC-1:0])
                                      | (s_axil_wdata[N_SRC-1:0] & wmask_s[N_SRC-1:0]);
                IDX_COUNT0:  count_d  = (count_q & ~wmask_s) | (s_axil_wdata & wmask_s);
                default:     clr_s    = '0;
            endcase
        end else begin
            clr_s = '0;
        end
        pending_d = (pending_q & ~clr_s) | edge_s;
    end

    // Read mux sampled from current state, so a same-cycle write is not yet visible.
    always_comb begin
        case (s_axil_araddr[4:2])
            IDX_PENDING: rd_val_s = zext(pending_q);
            IDX_ENABLE:  rd_val_s = zext(enable_q);
            IDX_STATUS:  rd_val_s = zext(pending_q & enable_q);
            IDX_CLAIM:   rd_val_s = lowest_idx(pending_q & enable_q);
            IDX_COUNT0:  rd_val_s = count_q;
            default:     rd_val_s = 32'd0;
        endcase
        if (!rd_ok_s) begin
            rd_val_s = 32'd0;
        end else begin
            rd_val_s = rd_val_s;
        end
    end

    // Response channel next state.
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (wr_acc_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (rd_acc_s) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_val_s;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Source synchronizers and edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= src_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Register file, response channels and irq.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            enable_q  <= '0;
            count_q   <= 32'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            count_q   <= count_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            irq_q     <= |(pending_q & enable_q);
        end
    end

    assign s_axil_awready = wr_acc_s;
    assign s_axil_wready  = wr_acc_s;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_s;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_axil_irq_ctrl.sv
// Directed and randomized bench for axil_irq_ctrl against a register-level model.
module tb_axil_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [3:0]  src_in;
    logic        irq;

    int n_checks = 0;
    int n_fails  = 0;

    logic [3:0]  m_pending, m_enable;
    logic [31:0] m_count;

    axil_irq_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .N_SRC(4)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .src_in(src_in), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bytes_of(input logic [3:0] s);
        logic [31:0] m;
        m = 32'd0;
        if (s[0]) m = m | 32'h0000_00FF;
        if (s[1]) m = m | 32'h0000_FF00;
        if (s[2]) m = m | 32'h00FF_0000;
        if (s[3]) m = m | 32'hFF00_0000;
        return m;
    endfunction

    // Expected read data straight from the register map description.
    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [3:0]  st;
        logic [31:0] claim;
        st = m_pending & m_enable;
        claim = 32'hFFFF_FFFF;
        for (int i = 3; i >= 0; i--) if (st[i]) claim = i;
        if (a > 8'h13) return 32'd0;
        case (a / 4)
            0: return {28'd0, m_pending};
            1: return {28'd0, m_enable};
            2: return {28'd0, st};
            3: return claim;
            4: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] bm;
        bm = bytes_of(s);
        if (a > 8'h13) return 2'b10;
        case (a / 4)
            0: m_pending = m_pending & ~(d[3:0] & bm[3:0]);
            1: m_enable  = (m_enable & ~bm[3:0]) | (d[3:0] & bm[3:0]);
            4: m_count   = (m_count & ~bm) | (d & bm);
            default: m_count = m_count;
        endcase
        return 2'b00;
    endfunction

    task automatic axil_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp, output logic irq_after);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        #1;
        while (!awready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("aw_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_after_accept", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        irq_after = irq;
    endtask

    task automatic axil_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("ar_accept", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid_after_accept", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        @(posedge clk);
    endtask

    task automatic write_chk(input string tag, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        logic [1:0] r, er;
        logic       ia;
        er = model_write(a, d, s);
        axil_write(a, d, s, r, ia);
        check({tag, "_bresp"}, 32'(r), 32'(er));
        check({tag, "_irq"}, 32'(ia), 32'(|(m_pending & m_enable)));
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        axil_read(a, d, r);
        check({tag, "_rdata"}, d, model_read(a));
        check({tag, "_rresp"}, 32'(r), (a > 8'h13) ? 32'd2 : 32'd0);
    endtask

    task automatic pulse(input logic [3:0] mask, input int hold);
        @(negedge clk);
        src_in = mask;
        repeat (hold) @(negedge clk);
        src_in = 4'h0;
        repeat (4) @(negedge clk);
        m_pending = m_pending | mask;
        if (mask[0]) m_count = m_count + 32'd1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 5; i++) read_chk(tag, 8'(i * 4));
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        rst = 1'b0; awaddr = 8'h00; araddr = 8'h00; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'd0; wstrb = 4'h0; src_in = 4'h0;
        m_pending = 4'h0; m_enable = 4'h0; m_count = 32'd0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        rst = 1'b1;
        #1;
        check("arready_out_of_reset", 32'(arready), 32'd1);
        read_all("reset_read");

        // 2: source 0 latency, count, claim, W1C
        write_chk("en1", 8'h04, 32'h1, 4'hF);
        @(negedge clk);
        src_in = 4'h1;
        repeat (3) @(posedge clk);
        #1;
        check("irq_before_4clk", 32'(irq), 32'd0);
        @(negedge clk);
        src_in = 4'h0;
        @(posedge clk); #1;
        check("irq_at_4clk", 32'(irq), 32'd1);
        m_pending = m_pending | 4'h1;
        m_count = m_count + 32'd1;
        read_chk("pend_src0", 8'h00);
        read_chk("count_src0", 8'h10);
        read_chk("claim_src0", 8'h0C);
        write_chk("w1c_src0", 8'h00, 32'h1, 4'hF);

        // 3: priority claim
        write_chk("enF", 8'h04, 32'hF, 4'hF);
        pulse(4'hC, 2);
        read_chk("status_c", 8'h08);
        read_chk("claim_2", 8'h0C);
        write_chk("clr2", 8'h00, 32'h4, 4'hF);
        read_chk("claim_3", 8'h0C);
        write_chk("clr3", 8'h00, 32'h8, 4'hF);
        read_chk("claim_none", 8'h0C);

        // 4: counter wrap and byte merge
        write_chk("cnt_max", 8'h10, 32'hFFFF_FFFF, 4'hF);
        pulse(4'h1, 3);
        read_chk("cnt_wrap", 8'h10);
        write_chk("cnt_full", 8'h10, 32'h1234_5678, 4'hF);
        write_chk("cnt_byte", 8'h10, 32'h0000_00AB, 4'h1);
        read_chk("cnt_merge", 8'h10);

        // 5: decode errors and back-pressure
        write_chk("bad_wr", 8'h14, 32'hFFFF_FFFF, 4'hF);
        read_chk("bad_rd", 8'h40);
        @(negedge clk);
        araddr = 8'h40; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        araddr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rhold_rvalid", 32'(rvalid), 32'd1);
            check("rhold_rresp", 32'(rresp), 32'd2);
            check("rhold_rdata", rdata, 32'd0);
            check("rhold_arready", 32'(arready), 32'd0);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        check("rhold_release", 32'(rvalid), 32'd0);
        @(negedge clk);
        awaddr = 8'h14; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awaddr = 8'h04;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bhold_bvalid", 32'(bvalid), 32'd1);
            check("bhold_bresp", 32'(bresp), 32'd2);
            check("bhold_awready", 32'(awready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        check("bhold_release", 32'(bvalid), 32'd0);
        read_all("after_errors");

        // 6: W before AW, edge vs W1C collision, reset mid-write
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h7; wstrb = 4'hF; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("w_only_awready", 32'(awready), 32'd0);
            check("w_only_wready", 32'(wready), 32'd0);
            @(negedge clk);
        end
        awvalid = 1'b1;
        #1;
        check("aw_join_wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk);
        m_enable = 4'h7;
        read_chk("enable_7", 8'h04);
        write_chk("clr_all", 8'h00, 32'hF, 4'hF);
        @(negedge clk);
        src_in = 4'h2;
        @(negedge clk);
        @(negedge clk);
        awaddr = 8'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        check("collide_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        src_in = 4'h0;
        m_pending = m_pending | 4'h2;
        read_chk("collide_pend", 8'h00);
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bready = 1'b1;
        m_pending = 4'h0; m_enable = 4'h0; m_count = 32'd0;
        read_all("after_rst");

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 7))
                0: a = 8'($urandom_range(0, 3));
                1: a = 8'(4 + $urandom_range(0, 3));
                2: a = 8'h08;
                3: a = 8'(12 + $urandom_range(0, 3));
                4: a = 8'(16 + $urandom_range(0, 3));
                5: a = 8'h14;
                6: a = 8'h40;
                default: a = 8'($urandom_range(0, 255));
            endcase
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: write_chk("rnd_wr", a, d, s);
                1: read_chk("rnd_rd", a);
                default: begin
                    pulse(4'($urandom_range(1, 15)), $urandom_range(2, 4));
                    check("rnd_irq", 32'(irq), 32'(|(m_pending & m_enable)));
                end
            endcase
        end
        read_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
